// File: rtl/hash_batch_job_buffer.sv
// Show-ahead batch FIFO in front of one match PE: tags the first batch of each job,
// counts complete jobs still buffered and flags batches routed to the wrong PE.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 4
`endif
`ifndef META_MATCH_LEN_WIDTH
`define META_MATCH_LEN_WIDTH 5
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef JOB_LEN_LOG2
`define JOB_LEN_LOG2 12
`endif

module hash_batch_job_buffer #(
   parameter logic [`NUM_JOB_PE_LOG2-1:0] IDX   = '0,
   parameter int                          DEPTH = 8
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                i_valid,
   input  logic [`ADDR_WIDTH-1:0]                              i_head_addr,
   input  logic [`HASH_ISSUE_WIDTH-1:0]                        i_history_valid,
   input  logic [`HASH_ISSUE_WIDTH*`ADDR_WIDTH-1:0]            i_history_addr,
   input  logic [`HASH_ISSUE_WIDTH*`META_MATCH_LEN_WIDTH-1:0]  i_meta_match_len,
   input  logic [`HASH_ISSUE_WIDTH-1:0]                        i_meta_match_can_ext,
   input  logic                                                i_delim,
   output logic                                                i_ready,
   output logic                                                o_valid,
   output logic [`ADDR_WIDTH-1:0]                              o_head_addr,
   output logic [`HASH_ISSUE_WIDTH-1:0]                        o_history_valid,
   output logic [`HASH_ISSUE_WIDTH*`ADDR_WIDTH-1:0]            o_history_addr,
   output logic [`HASH_ISSUE_WIDTH*`META_MATCH_LEN_WIDTH-1:0]  o_meta_match_len,
   output logic [`HASH_ISSUE_WIDTH-1:0]                        o_meta_match_can_ext,
   output logic                                                o_delim,
   output logic                                                o_job_first,
   input  logic                                                o_ready,
   output logic [$clog2(DEPTH):0]                              o_pending_jobs,
   output logic                                                o_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   function automatic logic [`NUM_JOB_PE_LOG2-1:0] pe_field(input logic [`ADDR_WIDTH-1:0] addr);
      return addr[`JOB_LEN_LOG2 +: `NUM_JOB_PE_LOG2];
   endfunction

   logic [`ADDR_WIDTH-1:0]                             mem_head_addr_r  [DEPTH];
   logic [`HASH_ISSUE_WIDTH-1:0]                       mem_hist_valid_r [DEPTH];
   logic [`HASH_ISSUE_WIDTH*`ADDR_WIDTH-1:0]           mem_hist_addr_r  [DEPTH];
   logic [`HASH_ISSUE_WIDTH*`META_MATCH_LEN_WIDTH-1:0] mem_mml_r        [DEPTH];
   logic [`HASH_ISSUE_WIDTH-1:0]                       mem_can_ext_r    [DEPTH];
   logic                                               mem_delim_r      [DEPTH];
   logic                                               mem_first_r      [DEPTH];

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] pending_r;
   logic          in_first_r;
   logic          err_r;
   logic          push_s;
   logic          pop_s;
   logic          push_delim_s;
   logic          pop_delim_s;

   // Handshake qualifiers derived only from registered occupancy.
   always_comb begin
      i_ready      = (count_r != FULL_CNT);
      o_valid      = (count_r != {CW{1'b0}});
      push_s       = i_valid && i_ready;
      pop_s        = o_valid && o_ready;
      push_delim_s = push_s && i_delim;
      pop_delim_s  = pop_s && mem_delim_r[rd_ptr_r];
   end

   // Storage array; intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_head_addr_r[wr_ptr_r]  <= i_head_addr;
         mem_hist_valid_r[wr_ptr_r] <= i_history_valid;
         mem_hist_addr_r[wr_ptr_r]  <= i_history_addr;
         mem_mml_r[wr_ptr_r]        <= i_meta_match_len;
         mem_can_ext_r[wr_ptr_r]    <= i_meta_match_can_ext;
         mem_delim_r[wr_ptr_r]      <= i_delim;
         mem_first_r[wr_ptr_r]      <= in_first_r;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // Job boundary tracking, complete-job count and sticky routing error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_first_r <= 1'b1;
         pending_r  <= {CW{1'b0}};
         err_r      <= 1'b0;
      end else begin
         if (push_s) begin
            in_first_r <= i_delim;
         end
         case ({push_delim_s, pop_delim_s})
            2'b10:   pending_r <= pending_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   pending_r <= pending_r - {{(CW-1){1'b0}}, 1'b1};
            default: pending_r <= pending_r;
         endcase
         if (push_s && (pe_field(i_head_addr) != IDX)) begin
            err_r <= 1'b1;
         end
      end
   end

   // Show-ahead head entry; when empty the first tag reports the next push.
   always_comb begin
      o_head_addr          = mem_head_addr_r[rd_ptr_r];
      o_history_valid      = mem_hist_valid_r[rd_ptr_r];
      o_history_addr       = mem_hist_addr_r[rd_ptr_r];
      o_meta_match_len     = mem_mml_r[rd_ptr_r];
      o_meta_match_can_ext = mem_can_ext_r[rd_ptr_r];
      o_delim              = mem_delim_r[rd_ptr_r];
      o_pending_jobs       = pending_r;
      o_err                = err_r;
      if (o_valid) begin
         o_job_first = mem_first_r[rd_ptr_r];
      end else begin
         o_job_first = in_first_r;
      end
   end

endmodule

// File: doc/hash_batch_job_buffer.md
Name: hash_batch_job_buffer

Overview:
Per-PE input buffer placed directly downstream of the hash batch bus node's "this" output. It absorbs hash batches routed to job PE IDX in a show-ahead FIFO, so bus backpressure is decoupled from match-PE stalls. It tags the first batch of every job and counts jobs whose delimiter has arrived but not yet drained. It also flags batches whose head address does not belong to this PE.

Parameters:
IDX, 0, job PE index this buffer serves; width `NUM_JOB_PE_LOG2
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  batch valid from bus node
i_head_addr  in  `ADDR_WIDTH  batch head address
i_history_valid  in  `HASH_ISSUE_WIDTH  per-lane history valid
i_history_addr  in  `HASH_ISSUE_WIDTH*`ADDR_WIDTH  per-lane history address
i_meta_match_len  in  `HASH_ISSUE_WIDTH*`META_MATCH_LEN_WIDTH  per-lane meta match length
i_meta_match_can_ext  in  `HASH_ISSUE_WIDTH  per-lane can-extend flag
i_delim  in  1  last batch of job
i_ready  out  1  buffer can accept
o_valid  out  1  head entry valid
o_head_addr, o_history_valid, o_history_addr, o_meta_match_len, o_meta_match_can_ext, o_delim  out  same widths as inputs  head entry fields
o_job_first  out  1  head entry is first batch of its job
o_ready  in  1  match PE accepts head entry
o_pending_jobs  out  $clog2(DEPTH)+1  complete jobs (delim accepted) not yet popped
o_err  out  1  sticky: accepted batch routed to wrong PE

Behaviour:
- push = i_valid && i_ready; pop = o_valid && o_ready.
- Storage is an array of DEPTH entries. Each entry holds the payload plus a first bit.
- Write and read pointers are $clog2(DEPTH) bits and wrap naturally. An occupancy counter is $clog2(DEPTH)+1 bits.
- i_ready = (count != DEPTH). It is registered-derived and does not depend on i_valid or o_ready.
- o_valid = (count != 0). Output fields are driven combinationally from mem[rd_ptr] (show-ahead).
- Latency: a batch pushed in cycle N is visible on the output in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal whenever 0 < count < DEPTH.
- Full: i_ready=0 and pop alone frees a slot. The next cycle then shows i_ready=1.
- Empty: o_valid=0, and o_ready is ignored.
- o_valid/payload stability: while o_valid && !o_ready, the output entry must not change.
- First tag: register in_first, reset value 1.
  - On push, the entry's first bit = in_first.
  - After the push, in_first becomes 1 if i_delim, else 0.
  - A single-batch job gets first=1 and delim=1.
- pending counter, reset value 0:
  - +1 on push with i_delim.
  - -1 on pop with o_delim.
  - Both in the same cycle: unchanged.
  - It never exceeds DEPTH.
- Error check: the PE field of i_head_addr is bits [`JOB_LEN_LOG2 +: `NUM_JOB_PE_LOG2].
  - On a push with field != IDX, o_err is set to 1.
  - o_err is cleared only by reset. The batch is still stored and forwarded.
- Reset (asynchronous, any time, including mid-job or when full):
  - Pointers, count, and pending reset to 0; in_first resets to 1; o_err resets to 0.
  - Outputs after reset: o_valid=0, i_ready=1, o_job_first=1, o_pending_jobs=0, o_err=0.
  - Payload outputs are don't-care while o_valid=0. The memory array is not reset.
- Partially buffered jobs are discarded by reset. The upstream is also reset, so nothing is resent.

Test Plan:
- Reset, then push one batch (head_addr with PE field = IDX, delim=1) with o_ready=1 → o_valid rises the next cycle; o_job_first=1, o_delim=1; o_pending_jobs reads 1 then 0 after the pop; o_err=0.
- With DEPTH=8 and o_ready=0, push 8 non-delim batches → i_ready=0 after the 8th. A 9th i_valid is not accepted. Raising o_ready for 1 cycle restores i_ready the next cycle, and the outputs appear in push order (head_addr 0x100, 0x110, ...).
- Job of 3 batches (delim on the 3rd) followed by a job of 1 batch → first bits read 1,0,0,1 and delim bits read 0,0,1,1. o_pending_jobs peaks at 2 with o_ready=0.
- Continuous push and pop at count=4 for 20 cycles → count stays 4, no batch is lost or duplicated, and the pointers wrap correctly.
- Push a batch whose PE field = IDX+1 → o_err=1 from the next cycle and stays 1. The batch still emerges on the output. Only rst_n clears o_err.
- Assert rst_n=0 with 5 entries buffered and in_first=0 → o_valid=0 and o_pending_jobs=0 immediately (asynchronous). After release, the first pushed batch has o_job_first=1.
